alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
// Multi-cycle 32x32 unsigned shift-and-add multiplier; drives the shared ALU as its initiator.
// Accepts operands via valid/ready and returns the low 32 product bits plus a sticky overflow flag.
// Issues 32-bit adds with flag write on the ALU, then reads the latched carry back the next cycle.
// Owns the ALU exclusively while Busy=1; top-level muxes ALU inputs by Busy.
// PARAMETERS
// ADD_FUNSEL   5'b10100  ALU FunSel for the 32-bit add with real carry-out (FunSel[4]=1).
// IDLE_FUNSEL  5'b10000  ALU FunSel driven in all non-ADD states (pass A, harmless).
// PORTS
// Clock        in   1   rising-edge clock
// Reset        in   1   synchronous, active-low reset
// StartValid   in   1   operand request valid
// StartReady   out  1   high only in IDLE
// OpA          in   32  multiplicand
// OpB          in   32  multiplier
// ResultValid  out  1   high only in DONE
// ResultReady  in   1   consumer accepts the result
// Product      out  32  low 32 bits of OpA*OpB; held stable while ResultValid=1
// Overflow     out  1   1 if the true 64-bit product exceeds 32 bits
// Busy         out  1   high in every state except IDLE
// AluA         out  32  = Acc register
// AluB         out  32  = Mcand register
// AluFunSel    out  5   ADD_FUNSEL in ADD, else IDLE_FUNSEL
// AluWF        out  1   1 only in ADD
// AluOut       in   32  combinational ALU result
// AluFlags     in   4   ALU registered flags {Z,C,N,O}; only C (bit 2) is used
// BEHAVIOUR
// Registers: state, Acc[31:0], Mcand[31:0], Mult[31:0], Ovf. Reset (Reset=0 at an edge): state=IDLE, all registers 0.
// Reset outputs: StartReady=1, ResultValid=0, Busy=0, Product=0, Overflow=0, AluWF=0, AluFunSel=IDLE_FUNSEL.
// IDLE: on StartValid=1 -> Acc=0, Mcand=OpA, Mult=OpB, Ovf=0, go EVAL. StartValid=0 -> stay.
// EVAL: Mult==0 -> DONE; Mult[0]=1 -> ADD; else -> SHIFT.
// ADD: AluWF=1, AluFunSel=ADD_FUNSEL; capture Acc<=AluOut at the edge; -> CHK.
// CHK: AluWF=0; Ovf<=Ovf|AluFlags[2] (carry latched by the ALU at the ADD edge); -> SHIFT.
// SHIFT: Ovf<=Ovf|(Mcand[31] & (Mult[31:1]!=0)); Mcand<=Mcand<<1; Mult<=Mult>>1; -> EVAL.
// DONE: Product=Acc, Overflow=Ovf; ResultReady=1 -> IDLE (StartReady high next cycle); else hold.
// Latency, accept edge to ResultValid: 2*(msb(OpB)+1) + 2*popcount(OpB) + 1 cycles; OpB=0 -> 1 cycle.
// StartValid while Busy: ignored; no request is queued (StartReady=0).
// Operand ports are sampled only at the accept edge; later changes have no effect.
// Product/Overflow: hold the last result after DONE->IDLE until the next accept; reset clears them.
// Reset mid-operation: abort immediately to the reset state; the in-flight result is discarded; no ALU write follows.
// Arithmetic is modulo 2^32. Overflow is sticky OR of: every ADD carry, and every set bit shifted out of Mcand while multiplier bits remain.
// TESTING
// OpA=3, OpB=5 -> ResultValid 11 cycles after accept; Product=15, Overflow=0; AluWF pulsed exactly twice.
// OpA=0x1234, OpB=0 -> ResultValid 1 cycle after accept; Product=0, Overflow=0; AluWF never asserted.
// OpA=0x60000000, OpB=3 -> Product=0x20000000, Overflow=1 (set in CHK from the ALU carry).
// OpA=0x80000000, OpB=2 -> Product=0, Overflow=1 (set in SHIFT by the shifted-out bit).
// Hold ResultReady=0 for 5 cycles in DONE; pulse StartValid -> outputs stable, no accept; ResultReady=1 -> IDLE.
// Drop Reset low during ADD of 3*5 -> next cycle IDLE, Busy=0, Product=0, AluWF=0; new 2*2 request returns 4.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle 32x32 unsigned shift-and-add multiplier that borrows the shared ALU for its adds.
// Returns the low 32 product bits plus a sticky overflow flag over a valid/ready pair.
module alu_mul_sequencer #(
    parameter logic [4:0] ADD_FUNSEL  = 5'b10100,
    parameter logic [4:0] IDLE_FUNSEL = 5'b10000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        StartValid,
    output logic        StartReady,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    output logic        ResultValid,
    input  logic        ResultReady,
    output logic [31:0] Product,
    output logic        Overflow,
    output logic        Busy,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags,
    output logic [2:0]  StateDbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends combinationally on ready, and request operands are sampled only then.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAL  = 3'd1,
        S_ADD   = 3'd2,
        S_CHK   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic       start_ready;
        logic       busy;
        logic       result_valid;
        logic       alu_wf;
        logic [4:0] funsel;
    } ctl_t;

    // Control outputs are registered together with the state they belong to.
    function automatic ctl_t ctl_for(input state_t s);
        ctl_t c;
        c.start_ready  = 1'b0;
        c.busy         = 1'b1;
        c.result_valid = 1'b0;
        c.alu_wf       = 1'b0;
        c.funsel       = IDLE_FUNSEL;
        case (s)
            S_IDLE: begin
                c.start_ready = 1'b1;
                c.busy        = 1'b0;
            end
            S_ADD: begin
                c.alu_wf = 1'b1;
                c.funsel = ADD_FUNSEL;
            end
            S_DONE:  c.result_valid = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t      state;
    ctl_t        ctl;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mult;
    logic        ovf;
    logic [31:0] product_q;
    logic        overflow_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= S_IDLE;
            ctl        <= ctl_for(S_IDLE);
            acc        <= '0;
            mcand      <= '0;
            mult       <= '0;
            ovf        <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (StartValid) begin
                        acc   <= '0;
                        mcand <= OpA;
                        mult  <= OpB;
                        ovf   <= 1'b0;
                        state <= S_EVAL;
                        ctl   <= ctl_for(S_EVAL);
                    end
                end
                S_EVAL: begin
                    if (mult == '0) begin
                        product_q  <= acc;
                        overflow_q <= ovf;
                        state      <= S_DONE;
                        ctl        <= ctl_for(S_DONE);
                    end else if (mult[0]) begin
                        state <= S_ADD;
                        ctl   <= ctl_for(S_ADD);
                    end else begin
                        state <= S_SHIFT;
                        ctl   <= ctl_for(S_SHIFT);
                    end
                end
                S_ADD: begin
                    acc   <= AluOut;
                    state <= S_CHK;
                    ctl   <= ctl_for(S_CHK);
                end
                S_CHK: begin
                    // The ALU latched the add carry at the ADD edge; it is readable only now.
                    ovf   <= ovf | AluFlags[2];
                    state <= S_SHIFT;
                    ctl   <= ctl_for(S_SHIFT);
                end
                S_SHIFT: begin
                    ovf   <= ovf | (mcand[31] & (mult[31:1] != '0));
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    state <= S_EVAL;
                    ctl   <= ctl_for(S_EVAL);
                end
                S_DONE: begin
                    if (ResultReady) begin
                        state <= S_IDLE;
                        ctl   <= ctl_for(S_IDLE);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ctl   <= ctl_for(S_IDLE);
                end
            endcase
        end
    end

    assign StartReady  = ctl.start_ready;
    assign Busy        = ctl.busy;
    assign ResultValid = ctl.result_valid;
    assign AluWF       = ctl.alu_wf;
    assign AluFunSel   = ctl.funsel;
    assign AluA        = acc;
    assign AluB        = mcand;
    assign Product     = product_q;
    assign Overflow    = overflow_q;
    assign StateDbg    = state;

    logic unused_flags;
    assign unused_flags = ^{AluFlags[3], AluFlags[1:0]};

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural model of the shared ALU.
// Vector table covers product, overflow, latency and ALU write count; hand sequences cover hold and reset.
module tb_alu_mul_sequencer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        StartValid = 1'b0;
    logic        StartReady;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        ResultValid;
    logic        ResultReady = 1'b0;
    logic [31:0] Product;
    logic        Overflow;
    logic        Busy;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;
    logic [2:0]  StateDbg;

    alu_mul_sequencer dut (
        .Clock(Clock), .Reset(Reset),
        .StartValid(StartValid), .StartReady(StartReady),
        .OpA(OpA), .OpB(OpB),
        .ResultValid(ResultValid), .ResultReady(ResultReady),
        .Product(Product), .Overflow(Overflow), .Busy(Busy),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags), .StateDbg(StateDbg)
    );

    always #5 Clock = ~Clock;

    // Shared ALU model: combinational result, flags {Z,C,N,O} written on the edge when AluWF=1.
    logic [32:0] alu_sum;
    logic [3:0]  alu_flags_q = 4'h0;
    assign alu_sum  = {1'b0, AluA} + {1'b0, AluB};
    assign AluOut   = (AluFunSel == 5'b10100) ? alu_sum[31:0] : AluA;
    assign AluFlags = alu_flags_q;
    always_ff @(posedge Clock) begin
        if (AluWF) alu_flags_q <= {alu_sum[31:0] == 32'd0, alu_sum[32], alu_sum[31], 1'b0};
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        logic        ovf;
        int          lat;
        int          wf;
    } vec_t;

    vec_t vecs[10];

    // Issues one request, then optionally stalls the result for `hold` cycles
    // while poking StartValid, and finally consumes it.
    task automatic run_op(input vec_t v, input int hold);
        int          cyc;
        int          wf;
        int          guard;
        logic [31:0] held_p;
        logic        held_o;
        guard = 0;
        while (!StartReady && guard < 300) begin
            @(negedge Clock);
            guard++;
        end
        check("start_ready_before_accept", {31'd0, StartReady}, 32'd1);
        OpA = v.a;
        OpB = v.b;
        StartValid = 1'b1;
        @(negedge Clock);
        StartValid = 1'b0;
        OpA = $urandom;
        OpB = $urandom;
        check("busy_after_accept", {31'd0, Busy}, 32'd1);
        cyc = 0;
        wf = 0;
        while (!ResultValid && cyc < 300) begin
            if (AluWF) wf++;
            @(negedge Clock);
            cyc++;
        end
        check("latency", cyc, v.lat);
        check("product", Product, v.prod);
        check("overflow", {31'd0, Overflow}, {31'd0, v.ovf});
        check("alu_wf_pulses", wf, v.wf);
        check("start_ready_in_done", {31'd0, StartReady}, 32'd0);
        held_p = Product;
        held_o = Overflow;
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                StartValid = 1'b1;
                OpA = 32'd9;
                OpB = 32'd9;
            end
            @(negedge Clock);
            StartValid = 1'b0;
            check("hold_result_valid", {31'd0, ResultValid}, 32'd1);
            check("hold_product", Product, held_p);
            check("hold_overflow", {31'd0, Overflow}, {31'd0, held_o});
            check("hold_start_ready", {31'd0, StartReady}, 32'd0);
        end
        ResultReady = 1'b1;
        @(negedge Clock);
        ResultReady = 1'b0;
        check("idle_start_ready", {31'd0, StartReady}, 32'd1);
        check("idle_busy", {31'd0, Busy}, 32'd0);
        check("idle_result_valid", {31'd0, ResultValid}, 32'd0);
        check("idle_product_held", Product, v.prod);
        check("idle_overflow_held", {31'd0, Overflow}, {31'd0, v.ovf});
    endtask

    initial begin
        vec_t v;
        int   guard;

        vecs[0] = '{32'd3,          32'd5,          32'd15,         1'b0, 11,  2};
        vecs[1] = '{32'h0000_1234,  32'd0,          32'd0,          1'b0, 1,   0};
        vecs[2] = '{32'h6000_0000,  32'd3,          32'h2000_0000,  1'b1, 9,   2};
        vecs[3] = '{32'h8000_0000,  32'd2,          32'd0,          1'b1, 7,   1};
        vecs[4] = '{32'd7,          32'd1,          32'd7,          1'b0, 5,   1};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b1, 129, 32};
        vecs[6] = '{32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 37,  1};
        vecs[7] = '{32'd0,          32'hFFFF_FFFF,  32'd0,          1'b0, 129, 32};
        vecs[8] = '{32'h0001_0001,  32'h0000_FFFF,  32'hFFFF_FFFF,  1'b0, 65,  16};
        vecs[9] = '{32'd12345,      32'd1000,       32'd12345000,   1'b0, 33,  6};

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_start_ready", {31'd0, StartReady}, 32'd1);
        check("rst_result_valid", {31'd0, ResultValid}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_product", Product, 32'd0);
        check("rst_overflow", {31'd0, Overflow}, 32'd0);
        check("rst_alu_wf", {31'd0, AluWF}, 32'd0);
        check("rst_funsel", {27'd0, AluFunSel}, 32'd16);
        check("rst_alu_a", AluA, 32'd0);
        check("rst_alu_b", AluB, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 10; i++) run_op(vecs[i], 0);

        // Result stalled in DONE for 5 cycles with a stray request in the middle
        run_op(vecs[0], 5);
        @(negedge Clock);
        check("no_accept_after_hold", {31'd0, Busy}, 32'd0);

        // Reset dropped while the first add of 3*5 is on the ALU
        OpA = 32'd3;
        OpB = 32'd5;
        StartValid = 1'b1;
        @(negedge Clock);
        StartValid = 1'b0;
        guard = 0;
        while (!AluWF && guard < 50) begin
            @(negedge Clock);
            guard++;
        end
        check("reached_add", {31'd0, AluWF}, 32'd1);
        Reset = 1'b0;
        @(negedge Clock);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_start_ready", {31'd0, StartReady}, 32'd1);
        check("abort_product", Product, 32'd0);
        check("abort_alu_wf", {31'd0, AluWF}, 32'd0);
        check("abort_result_valid", {31'd0, ResultValid}, 32'd0);
        Reset = 1'b1;
        @(negedge Clock);
        check("post_abort_alu_wf", {31'd0, AluWF}, 32'd0);
        check("post_abort_busy", {31'd0, Busy}, 32'd0);
        v = '{32'd2, 32'd2, 32'd4, 1'b0, 7, 1};
        run_op(v, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
